// File: rtl/hidden_layer_reg.sv
// Hidden-layer activation bank: ReLU + shift/saturate requantisation of MAC results,
// stored in order into NUM_NEURONS byte registers exposed as one packed bus.
module hidden_layer_reg #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 20,
    parameter int SHIFT       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic signed [ACC_W-1:0]       acc_in,
    input  logic                          acc_valid,
    output logic                          acc_ready,
    output logic [NUM_NEURONS*DATA_W-1:0] reg_hid,
    output logic [4:0]                    count,
    output logic                          full,
    output logic                          layer_done
);

    localparam logic [ACC_W-1:0] SAT_VAL = ACC_W'((1 << DATA_W) - 1);
    localparam logic [4:0]       LAST    = 5'(NUM_NEURONS - 1);

    logic [DATA_W-1:0] entries [NUM_NEURONS];
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0] act;
    logic              transfer;

    // Negative results clamp to zero; positive ones are truncated then saturated.
    always_comb begin
        shifted = $unsigned(acc_in) >> SHIFT;
        act     = '0;
        if (!acc_in[ACC_W-1]) begin
            if (shifted > SAT_VAL) begin
                act = '1;
            end else begin
                act = shifted[DATA_W-1:0];
            end
        end
    end

    assign acc_ready = !rst && !full && !clear;
    assign transfer  = acc_valid && acc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            full       <= 1'b0;
            layer_done <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            full       <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (transfer) begin
                count <= count + 5'd1;
                if (count == LAST) begin
                    full       <= 1'b1;
                    layer_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) entries[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_NEURONS; i++) entries[i] <= '0;
        end else if (transfer) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (count == 5'(i)) entries[i] <= act;
            end
        end
    end

    always_comb begin
        reg_hid = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            reg_hid[i*DATA_W +: DATA_W] = entries[i];
        end
    end

endmodule

// File: tb/tb_hidden_layer_reg.sv
// Randomised self-checking bench for hidden_layer_reg against an arithmetic
// reference model of the activation bank.
module tb_hidden_layer_reg;

    localparam int N  = 30;
    localparam int DW = 8;
    localparam int AW = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic signed [AW-1:0] acc_in;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [N*DW-1:0]      reg_hid;
    logic [4:0]           count;
    logic                 full;
    logic                 layer_done;

    int n_vec = 0;
    int n_err = 0;

    int m_mem [N];
    int m_count;
    bit m_full;

    hidden_layer_reg #(.NUM_NEURONS(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .acc_in(acc_in), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .reg_hid(reg_hid), .count(count), .full(full),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    function automatic int ref_f(logic [AW-1:0] a);
        int s;
        s = signed'(a);
        if (s < 0) return 0;
        s = s / 256;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [N*DW-1:0] model_bus();
        logic [N*DW-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) e[i*DW +: DW] = 8'(m_mem[i]);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = 0;
        m_count = 0;
        m_full  = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] a, input bit c);
        acc_valid = v;
        acc_in    = a;
        clear     = c;
        #1;
    endtask

    // Advances the model with the inputs present at the edge, then lets the DUT settle.
    task automatic tick();
        if (clear) begin
            model_reset();
        end else if (acc_valid && !m_full) begin
            m_mem[m_count] = ref_f(acc_in);
            m_count++;
            if (m_count == N) m_full = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_vec++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", acc_ready); end
        n_vec++; if (reg_hid !== '0) begin n_err++; $display("FAIL rst_bus: got %h want 0", reg_hid); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'($urandom), 1'b0);
            tick();
        end
        n_vec++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL pre_rst_count: got %0d want %0d", count, m_count); end
        n_vec++; if (reg_hid !== model_bus()) begin n_err++; $display("FAIL pre_rst_bus: got %h want %h", reg_hid, model_bus()); end
        drive(1'b0, '0, 1'b0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_vec++; if (reg_hid !== '0) begin n_err++; $display("FAIL async_rst_bus: got %h want 0", reg_hid); end
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", count); end
        n_vec++; if (full !== 1'b0 || layer_done !== 1'b0) begin n_err++; $display("FAIL async_rst_flags: got full=%b done=%b want 0 0", full, layer_done); end
        n_vec++; if (acc_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %b want 0", acc_ready); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", acc_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_fill();
        drive(1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < N; i++) begin
            drive(1'b1, AW'(i << 8), 1'b0);
            n_vec++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, acc_ready); end
            tick();
            n_vec++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, m_count); end
            n_vec++; if (layer_done !== (i == N - 1)) begin n_err++; $display("FAIL fill_done[%0d]: got %b want %b", i, layer_done, (i == N - 1)); end
        end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_vec++; if (acc_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_drop: got %b want 0", acc_ready); end
        for (int j = 0; j < N; j++) begin
            n_vec++; if (reg_hid[j*DW +: DW] !== 8'(j)) begin n_err++; $display("FAIL fill_byte[%0d]: got %0d want %0d", j, reg_hid[j*DW +: DW], j); end
        end
        drive(1'b0, '0, 1'b0);
        tick();
        n_vec++; if (layer_done !== 1'b0 || full !== 1'b1) begin n_err++; $display("FAIL fill_after: got done=%b full=%b want 0 1", layer_done, full); end
    endtask

    task automatic test_transfer_function();
        logic [AW-1:0] vals [6];
        int            want [6];
        vals = '{20'h80000, 20'hFFFFF, 20'h00180, 20'h0FF00, 20'h10000, 20'h7FFFF};
        want = '{0, 0, 1, 255, 255, 255};
        drive(1'b0, '0, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, vals[k], 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (reg_hid[k*DW +: DW] !== 8'(want[k])) begin n_err++; $display("FAIL xfer_byte[%0d]: got %0d want %0d", k, reg_hid[k*DW +: DW], want[k]); end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: drive(1'b1, AW'(20'h80000 | ($urandom & 32'h7FFFF)), 1'b0);
                1: drive(1'b1, AW'($urandom_range(0, 32'hFFFF)), 1'b0);
                2: drive(1'b1, AW'($urandom_range(32'hFE00, 32'h10200)), 1'b0);
                default: drive(1'b1, AW'($urandom), 1'b0);
            endcase
            tick();
        end
        n_vec++; if (reg_hid !== model_bus()) begin n_err++; $display("FAIL xfer_random_bus: got %h want %h", reg_hid, model_bus()); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 20'h05000, 1'b0);
            n_vec++; if (acc_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, acc_ready); end
            tick();
            n_vec++; if (reg_hid !== model_bus()) begin n_err++; $display("FAIL bp_bus[%0d]: got %h want %h", i, reg_hid, model_bus()); end
            n_vec++; if (layer_done !== 1'b0 || count !== 5'(N)) begin n_err++; $display("FAIL bp_state[%0d]: got done=%b count=%0d want 0 %0d", i, layer_done, count, N); end
        end
    endtask

    task automatic test_clear_collision();
        drive(1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, AW'($urandom_range(0, 32'h3FFFF)), 1'b0);
            tick();
        end
        n_vec++; if (count !== 5'd12) begin n_err++; $display("FAIL clr_pre_count: got %0d want 12", count); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 20'h07700, 1'b1);
            n_vec++; if (acc_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready[%0d]: got %b want 0", c, acc_ready); end
            tick();
            n_vec++; if (count !== 5'd0 || reg_hid !== '0) begin n_err++; $display("FAIL clr_empty[%0d]: got count=%0d bus=%h want 0 0", c, count, reg_hid); end
        end
        drive(1'b1, 20'h03400, 1'b0);
        tick();
        n_vec++; if (reg_hid[DW-1:0] !== 8'h34 || count !== 5'd1) begin n_err++; $display("FAIL clr_resume: got byte0=%h count=%0d want 34 1", reg_hid[DW-1:0], count); end
        n_vec++; if (reg_hid !== model_bus()) begin n_err++; $display("FAIL clr_resume_bus: got %h want %h", reg_hid, model_bus()); end
    endtask

    task automatic test_gapped_stream();
        int pulses = 0;
        int cycles = 0;
        drive(1'b0, '0, 1'b1);
        tick();
        while (m_count < N && cycles < 400) begin
            drive(1'($urandom_range(0, 1)), AW'(m_count * 256 + $urandom_range(0, 255)), 1'b0);
            tick();
            cycles++;
            if (layer_done === 1'b1) pulses++;
            n_vec++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL gap_count[%0d]: got %0d want %0d", cycles, count, m_count); end
        end
        n_vec++; if (m_count != N) begin n_err++; $display("FAIL gap_timeout: got %0d transfers want %0d", m_count, N); end
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom), 1'b0);
            tick();
            if (layer_done === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
        for (int j = 0; j < N; j++) begin
            n_vec++; if (reg_hid[j*DW +: DW] !== 8'(j)) begin n_err++; $display("FAIL gap_byte[%0d]: got %0d want %0d", j, reg_hid[j*DW +: DW], j); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        acc_valid = 1'b0;
        acc_in    = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        test_reset();
        test_full_fill();
        test_transfer_function();
        test_backpressure();
        test_clear_collision();
        test_gapped_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hidden_layer_reg.md
# hidden_layer_reg

Hidden-layer activation register for the two-layer neural processor. It accepts one signed accumulator result per neuron from the hidden-layer MAC. Each result is passed through ReLU and requantised to 8 bits, then stored in a 30-entry register bank. The bank is presented as the packed `reg_hid` bus that the input selector muxes into the output-layer datapath.

## Interface

Parameters:
- `NUM_NEURONS`, 30, number of hidden neurons / stored entries
- `DATA_W`, 8, stored activation width (unsigned)
- `ACC_W`, 20, accumulator input width (signed, two's complement)
- `SHIFT`, 8, right-shift applied to positive accumulator values before saturation

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `clear`  input  1  synchronous start-of-layer: empties the bank
- `acc_in`  input  ACC_W  signed accumulator result for the next neuron
- `acc_valid`  input  1  `acc_in` is valid this cycle
- `acc_ready`  output  1  bank can accept `acc_in` this cycle
- `reg_hid`  output  NUM_NEURONS*DATA_W  packed activations; neuron i at bits [i*DATA_W+DATA_W-1 : i*DATA_W]
- `count`  output  5  number of entries written since last clear/reset (0..NUM_NEURONS)
- `full`  output  1  all NUM_NEURONS entries written
- `layer_done`  output  1  one-cycle pulse when the bank becomes full

## Operation

- Storage: NUM_NEURONS × DATA_W registers plus a write counter `count`. Neurons are filled strictly in order 0, 1, …, NUM_NEURONS-1.
- Handshake:
  - `acc_ready = !rst && !full && !clear` (combinational).
  - A transfer occurs on a rising edge where `acc_valid && acc_ready`.
  - The producer holds `acc_in` stable until the transfer.
- On transfer, entry[`count`] ← f(`acc_in`) and `count` ← `count`+1.
- Transfer function f, with `acc_in` treated as signed ACC_W:
  - `acc_in` < 0 → 0 (ReLU).
  - Otherwise v = `acc_in` >> SHIFT (logical; value is non-negative).
  - If v > 2^DATA_W−1 → 2^DATA_W−1 (saturate to 255); else v[DATA_W-1:0].
  - Examples:
    - 0x00000 → 0
    - 0x00180 → 1 (truncation, no rounding)
    - 0x0FF00 → 255
    - 0x10000 → 255 (saturated)
    - 0x7FFFF → 255
    - 0x80000 → 0
- State (derived from `count`):
  - FILLING when `count` < NUM_NEURONS.
  - FULL when `count` == NUM_NEURONS.
- FILLING → FULL on the transfer that writes entry NUM_NEURONS-1. FULL → FILLING only via `clear` or `rst`.
- `full` is registered and equals (`count` == NUM_NEURONS).
- `layer_done` is registered. It is 1 for exactly the cycle after the final transfer, i.e. the first cycle `full` is 1.
- `clear`:
  - On the next edge: `count` ← 0, all entries ← 0, `full` ← 0, `layer_done` ← 0.
  - `clear` takes priority over a simultaneous `acc_valid`. No transfer occurs, because `acc_ready` is 0 while `clear` is high.
- `acc_valid` while FULL: ignored; no state change; `acc_ready` stays 0.
- `reg_hid` is driven directly from the registers; it is never tri-stated.

## Timing

- Reset (asynchronous assert, any time including mid-fill): `count`=0, all entries=0 (`reg_hid`=0), `full`=0, `layer_done`=0, `acc_ready`=0 while `rst` is high. After `rst` deasserts, `acc_ready`=1 in the first cycle.
- Write latency: entry visible on `reg_hid` and `count` incremented one cycle after the transfer edge.
- Throughput: one transfer per cycle with back-to-back `acc_valid`. 30 transfers fill the bank in 30 consecutive cycles.
- `full` and `layer_done` rise on the same edge that registers the 30th entry. `acc_ready` falls combinationally in that same cycle.
- `clear` held for multiple cycles: bank stays empty and `acc_ready` stays 0 throughout. Filling resumes the cycle after `clear` drops.
- No combinational path from `acc_in` to any output.

## Test plan

- Reset mid-fill: write 10 entries, assert `rst` asynchronously between edges → `reg_hid`=0, `count`=0, `full`=0 immediately, without waiting for an edge; `acc_ready`=1 after release.
- Full sequential fill: 30 back-to-back transfers with `acc_in` = i<<8 for i=0..29 → byte i of `reg_hid` = i; `full`=1 and `layer_done`=1 for one cycle after the 30th transfer; `count`=30.
- Transfer function: transfers of 0x80000, 0xFFFFF, 0x00180, 0x0FF00, 0x10000, 0x7FFFF → bytes 0..5 = 0, 0, 1, 255, 255, 255.
- Backpressure when full: keep `acc_valid`=1 with `acc_in`=0x05000 for 5 cycles after full → `acc_ready`=0, `reg_hid` unchanged, `layer_done` does not re-pulse.
- Clear vs valid collision: assert `clear` and `acc_valid` together at `count`=12 → next cycle `count`=0, `reg_hid`=0, no entry written. The next transfer lands in byte 0.
- Gapped stream: `acc_valid` toggling randomly over 30 transfers → entries land in order with no skipped or duplicated indices; `layer_done` pulses exactly once.
